// File: rtl/booth_mult32.sv
// Iterative radix-2 Booth signed multiplier: 32 add/sub/shift iterations, low-word result
// plus a flag for products that do not fit in 32 signed bits. Optional: BOOTH_ZERO_BYPASS_EN.
module booth_mult32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             data_exception,
  output logic             data_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_e;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_ready;
  logic             r_busy;

  logic [1:0]       w_recode;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_sign;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;
  logic             w_e_n;
  logic             w_exc_n;
  logic             w_start;
  logic             w_zero_op;

  assign w_recode = {r_lo[0], r_e};

  always_comb begin
    w_y   = '0;
    w_cin = 1'b0;
    case (w_recode)
      2'b01:   w_y = r_m;
      2'b10: begin
        w_y   = ~r_m;
        w_cin = 1'b1;
      end
      default: w_y = '0;
    endcase
  end

  // Adder stage: Sum plus signed overflow, as produced by adder32.
  assign w_sum_ext = {1'b0, r_hi} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  assign w_ovf     = (r_hi[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != r_hi[WIDTH-1]);
  // True 33rd sign bit of the partial sum; needed when M = -2^31.
  assign w_sign    = w_sum[WIDTH-1] ^ w_ovf;

  assign w_hi_n  = {w_sign, w_sum[WIDTH-1:1]};
  assign w_lo_n  = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_e_n   = r_lo[0];
  assign w_exc_n = !((&{w_hi_n, w_lo_n[WIDTH-1]}) || !(|{w_hi_n, w_lo_n[WIDTH-1]}));

  assign w_start = ctrl_start && (r_state != StRun);

`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_zero_op = (data_a == '0) || (data_b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_m         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_e         <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (w_start) begin
        r_m   <= data_a;
        r_hi  <= '0;
        r_e   <= 1'b0;
        r_cnt <= '0;
        if (w_zero_op) begin
          r_lo        <= '0;
          r_result    <= '0;
          r_exception <= 1'b0;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= StDone;
        end else begin
          r_lo    <= data_b;
          r_busy  <= 1'b1;
          r_state <= StRun;
        end
      end else begin
        case (r_state)
          StRun: begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_e   <= w_e_n;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(WIDTH - 1)) begin
              r_result    <= w_lo_n;
              r_exception <= w_exc_n;
              r_ready     <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= StDone;
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign result         = r_result;
  assign data_exception = r_exception;
  assign data_ready     = r_ready;
  assign busy           = r_busy;

endmodule

// File: tb/tb_booth_mult32.sv
// Self-checking bench for booth_mult32: directed and random operands against a
// 64-bit arithmetic reference; honours BOOTH_ZERO_BYPASS_EN for expected latency.
module tb_booth_mult32;

  logic        clock;
  logic        reset_n;
  logic        ctrl_start;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] result;
  logic        data_exception;
  logic        data_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  booth_mult32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .data_a         (data_a),
    .data_b         (data_b),
    .result         (result),
    .data_exception (data_exception),
    .data_ready     (data_ready),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint lo_ext;
    p = longint'($signed(a)) * longint'($signed(b));
    lo_ext = longint'($signed(p[31:0]));
    return p != lo_ext;
  endfunction

  // Edges after the start edge until data_ready is seen.
  function automatic int model_edges(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) return 0;
`endif
    return 32;
  endfunction

  // Starts an operation and waits (bounded) for data_ready; leaves the bench in the DONE cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    int busy_cnt;
    data_a     = a;
    data_b     = b;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    data_a     = $urandom;
    data_b     = $urandom;
    n        = 0;
    busy_cnt = 0;
    while (!data_ready && n < 40) begin
      if (busy) busy_cnt++;
      step();
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(model_edges(a, b)));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(model_edges(a, b)));
    check({tag, ".result"}, 64'(result), 64'(model_res(a, b)));
    check({tag, ".exception"}, 64'(data_exception), 64'(model_exc(a, b)));
  endtask

  initial begin
    int n;
    int ready_cnt;
    logic [31:0] ra;
    logic [31:0] rb;

    reset_n    = 1'b0;
    ctrl_start = 1'b0;
    data_a     = '0;
    data_b     = '0;
    step();
    step();
    check("reset.result", 64'(result), 64'd0);
    check("reset.exception", 64'(data_exception), 64'd0);
    check("reset.ready", 64'(data_ready), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step();

    run_op("7x-3", 32'd7, -32'sd3);
    check("7x-3.const", 64'(result), 64'hFFFF_FFEB);
    step();
    check("7x-3.pulse_width", 64'(data_ready), 64'd0);

    run_op("maxx2", 32'h7FFF_FFFF, 32'd2);
    run_op("-65536x32768", -32'sd65536, 32'd32768);
    run_op("minx-1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("minx1", 32'h8000_0000, 32'd1);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000);
    run_op("1xmin", 32'd1, 32'h8000_0000);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = $urandom_range(0, 255) - 128;
      run_op("random", ra, rb);
    end

    // A start during RUN is ignored; a start in the DONE cycle chains immediately.
    data_a     = 32'd5;
    data_b     = 32'd6;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    n = 0;
    while (!data_ready && n < 40) begin
      ctrl_start = 1'b0;
      if (n == 9) begin
        ctrl_start = 1'b1;
        data_a     = 32'd9;
        data_b     = 32'd9;
      end
      step();
      n++;
    end
    ctrl_start = 1'b0;
    check("ignored.latency", 64'(n), 64'd32);
    check("ignored.result", 64'(result), 64'd30);
    check("ignored.exception", 64'(data_exception), 64'd0);
    data_a     = 32'd9;
    data_b     = 32'd9;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    check("b2b.ready_falls", 64'(data_ready), 64'd0);
    check("b2b.busy", 64'(busy), 64'd1);
    n = 1;
    while (!data_ready && n < 45) begin
      step();
      n++;
    end
    check("b2b.spacing", 64'(n), 64'd33);
    check("b2b.result", 64'(result), 64'd81);

    // Reset mid-run aborts with no data_ready.
    step();
    data_a     = 32'd100;
    data_b     = 32'd100;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    repeat (15) step();
    reset_n = 1'b0;
    #1;
    check("abort.result", 64'(result), 64'd0);
    check("abort.exception", 64'(data_exception), 64'd0);
    check("abort.ready", 64'(data_ready), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) ready_cnt++;
      step();
    end
    check("abort.no_ready", 64'(ready_cnt), 64'd0);
    run_op("3x4", 32'd3, 32'd4);
    step();

    run_op("0x12345678", 32'd0, 32'h1234_5678);
    step();
    run_op("87654321x0", 32'h8765_4321, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
